// File: rtl/gray_pkg.sv
// Shared constants and FSM state type for the Gray-code monitor blocks.
package gray_pkg;
  localparam int GRAY_W = 4;
  localparam int POS_W  = 8;

  typedef enum logic [1:0] {IDLE, TRACK, ERROR} gray_mon_state_t;
endpackage

// File: rtl/gray2bin.sv
// Parameterised combinational Gray-to-binary decoder.
// Bit i of the binary value is the XOR of Gray bits W-1 down to i.
module gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b[i] = ^g[W-1:i];
  end
endmodule

// File: rtl/gray_step_monitor.sv
// Gray step monitor: registers and decodes Gray samples, checks for
// single-step motion, tracks an up/down position count.
// Optional: define GRAY_MON_ERRCNT_EN to build a saturating step-error counter;
// otherwise err_cnt is tied to 0.
module gray_step_monitor
  import gray_pkg::*;
#(
  parameter int W  = GRAY_W,
  parameter int CW = POS_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  g_in,
  input  logic          in_valid,
  input  logic          clr,
  output logic [W-1:0]  bin_out,
  output logic          out_valid,
  output logic          up,
  output logic          down,
  output logic          wrap,
  output logic          step_err,
  output logic          err_sticky,
  output logic [CW-1:0] pos,
  output logic [7:0]    err_cnt
);
  localparam logic [W-1:0] MAXV = '1;
  localparam logic [W-1:0] ONE  = W'(1);

  gray_mon_state_t state, state_nxt;
  logic [W-1:0]  b, d, bin_nxt;
  logic [CW-1:0] pos_nxt;
  logic          ov_nxt, up_nxt, dn_nxt, wrap_nxt, se_nxt;

  gray2bin #(.W(W)) u_dec (.g(g_in), .b(b));

  // Modular distance from the last accepted value to the new sample
  assign d = b - bin_out;

  // Next-state and next-output decode; pulses default low every cycle
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_out;
    ov_nxt    = out_valid;
    pos_nxt   = pos;
    up_nxt    = 1'b0;
    dn_nxt    = 1'b0;
    wrap_nxt  = 1'b0;
    se_nxt    = 1'b0;
    if (clr) begin
      // clr wins over a same-cycle sample; bin_out deliberately holds
      state_nxt = IDLE;
      ov_nxt    = 1'b0;
      pos_nxt   = '0;
    end else if (in_valid) begin
      case (state)
        IDLE: begin
          bin_nxt   = b;
          ov_nxt    = 1'b1;
          state_nxt = TRACK;
        end
        TRACK: begin
          if (d == ONE) begin
            bin_nxt  = b;
            up_nxt   = 1'b1;
            wrap_nxt = (bin_out == MAXV);
            pos_nxt  = pos + 1'b1;
          end else if (d == MAXV) begin
            bin_nxt  = b;
            dn_nxt   = 1'b1;
            wrap_nxt = (bin_out == '0);
            pos_nxt  = pos - 1'b1;
          end else if (d != '0) begin
            bin_nxt   = b;
            se_nxt    = 1'b1;
            state_nxt = ERROR;
          end
        end
        ERROR: bin_nxt = b;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_out   <= '0;
      out_valid <= 1'b0;
      pos       <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bin_out   <= bin_nxt;
      out_valid <= ov_nxt;
      pos       <= pos_nxt;
      up        <= up_nxt;
      down      <= dn_nxt;
      wrap      <= wrap_nxt;
      step_err  <= se_nxt;
    end
  end

  assign err_sticky = (state == ERROR);

`ifdef GRAY_MON_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of step errors; only reset clears it, clr does not
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (se_nxt && err_cnt_q != 8'hFF)
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_gray_step_monitor.sv
// Scoreboard bench for gray_step_monitor: a behavioural model pushes the
// expected registered outputs as each input cycle is driven; they are popped
// and compared on the following falling edge.
module tb_gray_step_monitor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] g_in = '0;
  logic       in_valid = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] bin_out;
  logic       out_valid, up, down, wrap, step_err, err_sticky;
  logic [7:0] pos, err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] bin;
    logic       ov, up, dn, wr, se, es;
    logic [7:0] pos, ec;
  } exp_t;

  exp_t sb[$];

  // model state: 0 IDLE, 1 TRACK, 2 ERROR
  int         m_st = 0;
  logic [3:0] m_bin = '0;
  logic       m_ov = 1'b0;
  logic [7:0] m_pos = '0;
  logic [7:0] m_ec = '0;

  gray_step_monitor dut (
    .clk(clk), .rst_n(rst_n), .g_in(g_in), .in_valid(in_valid), .clr(clr),
    .bin_out(bin_out), .out_valid(out_valid), .up(up), .down(down),
    .wrap(wrap), .step_err(step_err), .err_sticky(err_sticky),
    .pos(pos), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] x;
    x = 4'(n);
    return x ^ (x >> 1);
  endfunction

  // prefix-XOR decode, independent of the RTL formulation
  function automatic logic [3:0] dec(input logic [3:0] g);
    logic [3:0] x;
    x = g;
    x = x ^ (x >> 1);
    x = x ^ (x >> 2);
    return x;
  endfunction

  task automatic step(input logic r, input logic v, input logic c, input logic [3:0] g);
    exp_t e;
    logic [3:0] bb, dd;
    rst_n = r; in_valid = v; clr = c; g_in = g;
    e.up = 0; e.dn = 0; e.wr = 0; e.se = 0;
    bb = dec(g);
    if (!r) begin
      m_st = 0; m_bin = 0; m_ov = 0; m_pos = 0; m_ec = 0;
    end else if (c) begin
      m_st = 0; m_ov = 0; m_pos = 0;
    end else if (v) begin
      if (m_st == 0) begin
        m_bin = bb; m_ov = 1; m_st = 1;
      end else if (m_st == 1) begin
        dd = bb - m_bin;
        if (dd == 4'd1) begin
          e.up = 1; e.wr = (m_bin == 4'd15); m_pos = m_pos + 8'd1; m_bin = bb;
        end else if (dd == 4'd15) begin
          e.dn = 1; e.wr = (m_bin == 4'd0); m_pos = m_pos - 8'd1; m_bin = bb;
        end else if (dd != 4'd0) begin
          e.se = 1; m_bin = bb; m_st = 2;
`ifdef GRAY_MON_ERRCNT_EN
          if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
`endif
        end
      end else begin
        m_bin = bb;
      end
    end
    e.bin = m_bin; e.ov = m_ov; e.pos = m_pos; e.ec = m_ec; e.es = (m_st == 2);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk("bin_out", 32'(bin_out), 32'(e.bin));
    chk("out_valid", 32'(out_valid), 32'(e.ov));
    chk("up", 32'(up), 32'(e.up));
    chk("down", 32'(down), 32'(e.dn));
    chk("wrap", 32'(wrap), 32'(e.wr));
    chk("step_err", 32'(step_err), 32'(e.se));
    chk("err_sticky", 32'(err_sticky), 32'(e.es));
    chk("pos", 32'(pos), 32'(e.pos));
    chk("err_cnt", 32'(err_cnt), 32'(e.ec));
  endtask

  task automatic bstep(input int n);
    step(1'b1, 1'b1, 1'b0, to_gray(n));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'($urandom_range(15)));
  endtask

  task automatic do_clr();
    step(1'b1, 1'b0, 1'b1, 4'd0);
  endtask

  initial begin
    // reset
    step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd5);
    chk("rst_pos", 32'(pos), 32'd0);

    // Gray 0000,0001,0011,0010 -> binary 0..3
    step(1'b1, 1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b1, 1'b0, 4'b0011);
    step(1'b1, 1'b1, 1'b0, 4'b0010);
    chk("seq_pos", 32'(pos), 32'd3);
    chk("seq_bin", 32'(bin_out), 32'b0011);
    idle(2);
    bstep(3);                              // repeat: hold, no pulse

    // walk to 15, wrap up to 0, wrap back down to 15
    for (int n = 4; n <= 15; n++) bstep(n);
    step(1'b1, 1'b1, 1'b0, 4'b0000);
    chk("wrap_up_pos", 32'(pos), 32'd16);
    step(1'b1, 1'b1, 1'b0, 4'b1000);
    chk("wrap_dn_pos", 32'(pos), 32'd15);
    for (int n = 14; n >= 10; n--) bstep(n);

    // illegal step 2 -> 5, then 5 -> 6 ignored for direction
    do_clr();
    bstep(2);
    step(1'b1, 1'b1, 1'b0, 4'b0111);
    chk("err_sticky_set", 32'(err_sticky), 32'd1);
    bstep(6);
    idle(1);
    do_clr();
    chk("clr_pos", 32'(pos), 32'd0);

    // clr with a same-cycle sample, then re-entry to TRACK
    bstep(4);
    step(1'b1, 1'b1, 1'b1, to_gray(9));
    bstep(9);
    bstep(8);
    // clr asserted from IDLE with data
    step(1'b1, 1'b1, 1'b1, to_gray(1));

    // 300 illegal steps, clr after each
    for (int k = 0; k < 300; k++) begin
      bstep(0);
      bstep(5 + (k % 3));
      do_clr();
    end
`ifdef GRAY_MON_ERRCNT_EN
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
`else
    chk("err_cnt_off", 32'(err_cnt), 32'd0);
`endif

    // reset mid-TRACK with pos=5
    for (int n = 0; n <= 5; n++) bstep(n);
    chk("pre_rst_pos", 32'(pos), 32'd5);
    step(1'b0, 1'b1, 1'b0, to_gray(6));
    chk("rst_mid_pos", 32'(pos), 32'd0);
    bstep(7);
    bstep(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
- Downstream consumer of the 4-bit binary-to-Gray converter output (e.g. an encoder or pointer bus).
- Registers each incoming Gray sample and decodes it back to binary.
- Checks that consecutive samples differ by exactly one code step, and reports direction, wrap-around and step errors.
- Maintains an up/down position count. Used as the self-check and readback stage behind the code converters.

Parameters:
- W, 4, Gray/binary code width in bits (W >= 2).
- CW, 8, position counter width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- g_in  input  W  Gray-coded sample, MSB = bit W-1.
- in_valid  input  1  g_in is valid this cycle.
- clr  input  1  synchronous clear of error state and position; returns FSM to IDLE.
- bin_out  output  W  registered binary decode of the last accepted sample.
- out_valid  output  1  bin_out holds a decoded sample.
- up  output  1  one-cycle pulse: last sample = previous + 1 (mod 2^W).
- down  output  1  one-cycle pulse: last sample = previous - 1 (mod 2^W).
- wrap  output  1  one-cycle pulse: step crossed 2^W-1 <-> 0 in either direction.
- step_err  output  1  one-cycle pulse: illegal step, i.e. binary distance > 1.
- err_sticky  output  1  high while FSM is in ERROR.
- pos  output  CW  up/down step counter.
- err_cnt  output  8  error event counter (see Optional Feature).

Behaviour:
- Clocking: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: bin_out=0, out_valid=0, up=down=wrap=step_err=0, err_sticky=0, pos=0, err_cnt=0, state=IDLE.
- Decode (combinational on g_in):
  - b[W-1] = g[W-1].
  - b[i] = b[i+1] ^ g[i], for i = W-2 down to 0.
- Latency: all outputs register 1 cycle after the in_valid cycle. Pulses last exactly one cycle and are 0 on any cycle without an accepted sample.
- No backpressure: a sample is accepted on every cycle where in_valid=1.
- FSM states: IDLE, TRACK, ERROR.
- IDLE, in_valid=1:
  - bin_out<=b, out_valid<=1.
  - No pulses; pos unchanged.
  - Go to TRACK.
- TRACK, in_valid=1, with d = b - bin_out (mod 2^W):
  - d=0: hold. bin_out unchanged, no pulses.
  - d=1: up=1, pos+=1.
  - d=2^W-1: down=1, pos-=1.
  - Otherwise: step_err=1, bin_out<=b, pos unchanged, go to ERROR.
  - wrap=1 additionally when (prev=2^W-1, b=0) or (prev=0, b=2^W-1).
- ERROR:
  - err_sticky=1.
  - Samples are still decoded into bin_out, with no direction pulses, no step_err and no pos change.
  - Leaves only on clr or reset.
- clr (any state): next state IDLE, out_valid<=0, err_sticky<=0, pos<=0. bin_out holds its value. clr has priority over a same-cycle in_valid; that sample is discarded.
- Counter wrap: pos wraps modulo 2^CW in both directions with no saturation.
- in_valid=0: every register holds, except that pulses clear to 0.

Optional Feature:
- Macro: GRAY_MON_ERRCNT_EN.
- Defined: err_cnt increments on every step_err pulse and saturates at 255. It is cleared by rst_n only, not by clr.
- Undefined: err_cnt is tied to 0 and no counter logic is generated. The port is always present.

Decomposition:
- Shared package gray_pkg:
  - Default width constants GRAY_W=4, POS_W=8.
  - FSM state typedef gray_mon_state_t {IDLE, TRACK, ERROR}.
- Sub-module gray2bin, a parameterised combinational Gray-to-binary decoder. It is instantiated once here and reusable by a future Gray-to-binary converter.

Test Plan:
- Reset, then Gray sequence 0000,0001,0011,0010 (binary 0,1,2,3) -> up pulses on 2nd-4th samples, pos=3, bin_out=0011, no errors.
- Binary 15 then 0 (Gray 1000 then 0000) -> up=1 and wrap=1 in the same cycle, pos increments. Reverse order -> down=1, wrap=1, pos decrements.
- Binary 2 then 5 (Gray 0011 then 0111) -> step_err pulse, err_sticky=1. A further step 5->6 gives no up pulse and no pos change. clr -> IDLE, err_sticky=0, pos=0.
- clr and in_valid asserted in the same cycle -> sample ignored, out_valid=0. The next valid sample re-enters TRACK with no pulse.
- 300 alternating illegal steps with clr after each step_err -> err_cnt=255 when GRAY_MON_ERRCNT_EN is defined, 0 when undefined.
- rst_n=0 mid-sequence while in TRACK with pos=5 -> next cycle all outputs at reset values, state IDLE.
